// File: rtl/nic_if.sv
// -----------------------------------------------------------------------------
// nic_if : bundle of every signal crossing the NIC boundary.
//
// Processor side : addr, d_in, nicEn, nicWrEn   (PE -> NIC)
//                  d_out                        (NIC -> PE, registered)
// Router side    : net_si, net_ri, net_di, net_polarity  (router -> NIC)
//                  net_so, net_ro, net_do                (NIC -> router)
//
// Modport slave is the NIC's view; modport master is the PE/router
// (or testbench) view.
// -----------------------------------------------------------------------------
interface nic_if #(
    parameter int DATA_WIDTH = 64
);
    // processor register access
    logic [1:0]            addr;
    logic [DATA_WIDTH-1:0] d_in;
    logic [DATA_WIDTH-1:0] d_out;
    logic                  nicEn;
    logic                  nicWrEn;

    // router PE channel
    logic                  net_so;
    logic                  net_ro;
    logic [DATA_WIDTH-1:0] net_do;
    logic                  net_si;
    logic                  net_ri;
    logic [DATA_WIDTH-1:0] net_di;
    logic                  net_polarity;

    modport slave (
        input  addr, d_in, nicEn, nicWrEn,
        input  net_si, net_ri, net_di, net_polarity,
        output d_out, net_so, net_ro, net_do
    );

    modport master (
        output addr, d_in, nicEn, nicWrEn,
        output net_si, net_ri, net_di, net_polarity,
        input  d_out, net_so, net_ro, net_do
    );
endinterface

// File: rtl/nic.sv
// -----------------------------------------------------------------------------
// nic : network interface controller between a processing element and the
//       PE port of one mesh router. One packet deep in each direction.
//
// Ports
//   clk    : clock, all state changes on posedge
//   reset  : synchronous, active-high
//   bus    : nic_if.slave
//            addr/d_in/nicEn/nicWrEn -> 4-entry register map
//              00 in_buf (read pops), 01 in_status, 10 out_buf, 11 out_status
//            d_out  : registered read data, 1-cycle latency
//            net_so/net_do/net_ri : outbound channel to router pesi/pedi/peri
//            net_si/net_di/net_ro : inbound channel from router peso/pedo/pero
//            net_polarity         : router polarity, gates VC injection
// -----------------------------------------------------------------------------
module nic #(
    parameter int DATA_WIDTH = 64,
    parameter int VC_BIT     = 63
) (
    input  logic  clk,
    input  logic  reset,
    nic_if.slave  bus
);

    localparam logic [1:0] A_IN_BUF  = 2'b00;
    localparam logic [1:0] A_IN_STAT = 2'b01;
    localparam logic [1:0] A_OUT_BUF = 2'b10;
    localparam logic [1:0] A_OUT_STAT = 2'b11;

    logic [DATA_WIDTH-1:0] r_out_buf;
    logic                  r_out_full;
    logic [DATA_WIDTH-1:0] r_in_buf;
    logic                  r_in_full;
    logic [DATA_WIDTH-1:0] r_d_out;

    logic w_rd;
    logic w_wr_out;
    logic w_so;
    logic w_ro;
    logic w_accept;

    assign w_rd     = bus.nicEn & ~bus.nicWrEn;
    assign w_wr_out = bus.nicEn &  bus.nicWrEn & (bus.addr == A_OUT_BUF);

    // A packet may only be injected when its VC bit matches the router's
    // current polarity; otherwise it waits in out_buf for the next toggle.
    assign w_so = r_out_full & bus.net_ri &
                  (r_out_buf[VC_BIT] == bus.net_polarity) & ~reset;

    assign w_ro     = ~r_in_full & ~reset;
    assign w_accept = bus.net_si & w_ro;

    assign bus.net_so = w_so;
    assign bus.net_ro = w_ro;
    assign bus.net_do = r_out_buf;
    assign bus.d_out  = r_d_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_buf  <= '0;
            r_out_full <= 1'b0;
            r_in_buf   <= '0;
            r_in_full  <= 1'b0;
            r_d_out    <= '0;
        end else begin
            // Outbound: a write in the same cycle as a send still sees the
            // buffer full and is dropped, so the buffer refills no sooner
            // than the cycle after a send.
            if (w_so) begin
                r_out_full <= 1'b0;
            end else if (w_wr_out && !r_out_full) begin
                r_out_buf  <= bus.d_in;
                r_out_full <= 1'b1;
            end

            // Inbound: accept and pop are mutually exclusive because a full
            // buffer holds net_ro low.
            if (w_accept) begin
                r_in_buf  <= bus.net_di;
                r_in_full <= 1'b1;
            end else if (w_rd && (bus.addr == A_IN_BUF)) begin
                r_in_full <= 1'b0;
            end

            if (w_rd) begin
                unique case (bus.addr)
                    A_IN_BUF:   r_d_out <= r_in_buf;
                    A_IN_STAT:  r_d_out <= {{(DATA_WIDTH-1){1'b0}}, r_in_full};
                    A_OUT_STAT: r_d_out <= {{(DATA_WIDTH-1){1'b0}}, r_out_full};
                    default:    r_d_out <= '0;
                endcase
            end else begin
                r_d_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_nic.sv
// -----------------------------------------------------------------------------
// tb_nic : scoreboard bench for nic. Read expectations and expected outbound
// packets are queued as stimulus is issued; a monitor pops and compares them
// whenever d_out is due or net_so is high.
// -----------------------------------------------------------------------------
module tb_nic;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nic_if #(.DATA_WIDTH(DW)) bus ();

    nic #(.DATA_WIDTH(DW), .VC_BIT(63)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] rd_q[$];
    logic [DW-1:0] tx_q[$];
    bit            rd_seen = 1'b0;

    localparam logic [DW-1:0] PKT_A = 64'hC010_0000_1111_1111;
    localparam logic [DW-1:0] PKT_B = 64'h4000_0000_2222_2222;
    localparam logic [DW-1:0] PKT_C = 64'h8001_0000_3333_3333;
    localparam logic [DW-1:0] PKT_D = 64'h0002_0000_4444_4444;

    // ---------------- monitor ----------------
    always @(posedge clk) rd_seen = bus.nicEn && !bus.nicWrEn && !reset;

    always @(negedge clk) begin
        logic [DW-1:0] exp_v;
        if (rd_seen) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected d_out=%h no expectation queued", bus.d_out);
            end else begin
                exp_v = rd_q.pop_front();
                if (bus.d_out !== exp_v) begin
                    errors++;
                    $display("FAIL rd_data got=%h exp=%h", bus.d_out, exp_v);
                end
            end
        end
        if (bus.net_so === 1'b1) begin
            checks++;
            if (tx_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected net_do=%h no packet expected", bus.net_do);
            end else begin
                exp_v = tx_q.pop_front();
                if (bus.net_do !== exp_v) begin
                    errors++;
                    $display("FAIL tx_data got=%h exp=%h", bus.net_do, exp_v);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp_v);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [DW-1:0] exp_v);
        bus.nicEn = 1'b1; bus.nicWrEn = 1'b0; bus.addr = a;
        rd_q.push_back(exp_v);
        tick();
        bus.nicEn = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [DW-1:0] v, input bit will_send);
        bus.nicEn = 1'b1; bus.nicWrEn = 1'b1; bus.addr = a; bus.d_in = v;
        if (will_send) tx_q.push_back(v);
        tick();
        bus.nicEn = 1'b0; bus.nicWrEn = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        bus.addr = 2'b00; bus.d_in = '0; bus.nicEn = 1'b0; bus.nicWrEn = 1'b0;
        bus.net_si = 1'b0; bus.net_ri = 1'b0; bus.net_di = '0; bus.net_polarity = 1'b0;
        tick(); tick();
        settle();
        chk("rst_so", {63'b0, bus.net_so}, 64'd0);
        chk("rst_ro", {63'b0, bus.net_ro}, 64'd0);
        chk("rst_dout", bus.d_out, 64'd0);

        // 1: post-reset state
        reset = 1'b0;
        settle();
        chk("ro_after_rst", {63'b0, bus.net_ro}, 64'd1);
        chk("so_after_rst", {63'b0, bus.net_so}, 64'd0);
        rd(2'b01, 64'd0);
        rd(2'b11, 64'd0);

        // 2: matching VC sends immediately
        bus.net_ri = 1'b1; bus.net_polarity = 1'b1;
        wr(2'b10, PKT_A, 1'b1);
        settle();
        chk("t2_so", {63'b0, bus.net_so}, 64'd1);
        chk("t2_do", bus.net_do, PKT_A);
        tick();
        rd(2'b11, 64'd0);
        rd(2'b10, 64'd0);

        // 3: VC mismatch waits for polarity toggle, then one-cycle pulse
        bus.net_polarity = 1'b0;
        wr(2'b10, PKT_A, 1'b1);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t3_wait_so", {63'b0, bus.net_so}, 64'd0);
            tick();
        end
        bus.net_polarity = 1'b1;
        settle();
        chk("t3_so", {63'b0, bus.net_so}, 64'd1);
        tick();
        settle();
        chk("t3_so_off", {63'b0, bus.net_so}, 64'd0);

        // 4: write to full out_buf is dropped
        bus.net_ri = 1'b0;
        wr(2'b10, PKT_A, 1'b1);
        wr(2'b10, PKT_B, 1'b0);
        wr(2'b00, PKT_B, 1'b0);
        rd(2'b11, 64'd1);
        bus.net_ri = 1'b1;
        settle();
        chk("t4_do", bus.net_do, PKT_A);
        tick();
        settle();
        chk("t4_so_off", {63'b0, bus.net_so}, 64'd0);

        // 5: inbound packet, backpressure, pop, second packet
        bus.net_si = 1'b1; bus.net_di = PKT_C;
        tick();
        bus.net_di = PKT_D;
        settle();
        chk("t5_ro_low", {63'b0, bus.net_ro}, 64'd0);
        rd(2'b01, 64'd1);
        rd(2'b00, PKT_C);
        settle();
        chk("t5_ro_back", {63'b0, bus.net_ro}, 64'd1);
        tick();
        bus.net_si = 1'b0;
        settle();
        chk("t5_ro_low2", {63'b0, bus.net_ro}, 64'd0);
        rd(2'b00, PKT_D);
        rd(2'b00, PKT_D);
        rd(2'b01, 64'd0);

        // 6: reset discards both buffers
        bus.net_ri = 1'b0;
        wr(2'b10, PKT_B, 1'b0);
        bus.net_si = 1'b1; bus.net_di = PKT_C;
        tick();
        bus.net_si = 1'b0;
        rd(2'b01, 64'd1);
        rd(2'b11, 64'd1);
        reset = 1'b1;
        bus.net_ri = 1'b1; bus.net_polarity = 1'b0;
        settle();
        chk("t6_so_rst", {63'b0, bus.net_so}, 64'd0);
        chk("t6_ro_rst", {63'b0, bus.net_ro}, 64'd0);
        tick();
        reset = 1'b0;
        settle();
        chk("t6_dout", bus.d_out, 64'd0);
        chk("t6_ro", {63'b0, bus.net_ro}, 64'd1);
        chk("t6_so", {63'b0, bus.net_so}, 64'd0);
        rd(2'b01, 64'd0);
        rd(2'b11, 64'd0);

        tick(); tick();
        chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
        chk("tx_q_empty", 64'(tx_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nic.md
Name: nic

Overview:
- Network interface controller that sits between a processing element (PE) and the PE port of one mesh router.
- It presents a 4-entry register map to the processor: input buffer, input status, output buffer, output status.
- On the router side it drives the router's PE input channel (pesi/pedi/peri) and acts as the sink for the router's PE output channel (peso/pedo/pero).
- It is one 64-bit packet deep in each direction and obeys the router's polarity-based virtual-channel injection rule.

Parameters:
DATA_WIDTH, 64, packet width; packet format {vc[63], dir[62:61], rsvd[60:56], hop[55:48], src[47:32], data[31:0]}
VC_BIT, 63, bit index of the virtual-channel bit

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
addr  in  2  processor register select: 00 in_buf, 01 in_status, 10 out_buf, 11 out_status
d_in  in  DATA_WIDTH  processor write data
d_out  out  DATA_WIDTH  processor read data, registered
nicEn  in  1  processor access enable
nicWrEn  in  1  1 = write, 0 = read (qualified by nicEn)
net_so  out  1  send to router (connects to router pesi)
net_ro  out  1  ready to accept from router (connects to router pero)
net_do  out  DATA_WIDTH  packet to router (connects to router pedi)
net_si  in  1  router sending (router peso)
net_ri  in  1  router ready to accept (router peri)
net_di  in  DATA_WIDTH  packet from router (router pedo)
net_polarity  in  1  router polarity

Behaviour:
- State: out_buf, out_full, in_buf, in_full, d_out reg.
  - Synchronous reset on posedge with reset=1 clears all to 0.
  - net_so=0 and net_ro=0 while reset is high.
- Outbound path (processor -> router):
  - Write to 10 (nicEn & nicWrEn & addr==10) with out_full=0: out_buf<=d_in, out_full<=1 at that edge.
  - Same write with out_full=1 is silently dropped; no state change.
  - Writes to 00, 01 and 11 are ignored.
  - net_do = out_buf (combinational).
  - net_so = out_full & net_ri & (out_buf[VC_BIT]==net_polarity) & ~reset (combinational).
  - On a posedge with net_so=1, the transfer completes and out_full<=0.
  - A packet with non-matching VC waits, at most until polarity toggles; it is never dropped.
  - Write and send in the same cycle: the write sees out_full=1 (start-of-cycle value) and is dropped.
  - A new packet is accepted from the cycle after the send, giving a throughput of 1 packet per 2 cycles minimum.
- Inbound path (router -> processor):
  - net_ro = ~in_full & ~reset (combinational).
  - On a posedge with net_si & net_ro: in_buf<=net_di, in_full<=1.
  - net_si while net_ro=0 is ignored; the router holds the packet.
- Reads (nicEn & ~nicWrEn), 1-cycle latency, d_out updated at the edge:
  - 00: d_out<=in_buf, and in_full<=0 at the same edge. A read with in_full=0 returns the stale in_buf and changes nothing.
  - 01: d_out<={63'b0,in_full}.
  - 11: d_out<={63'b0,out_full}.
  - 10: d_out<=0.
  - No access (nicEn=0): d_out<=0.
- Read of 00 and router arrival in the same cycle are impossible: in_full=1 forces net_ro=0. The next packet can land the cycle after the read.
- Reset mid-operation: any pending packet in either buffer is discarded. net_so and net_ro go low in the same cycle reset is sampled high.
- The NIC performs no header inspection other than the VC bit; hop and direction are passed through unchanged.

Test Plan:
1. Reset, then read 01 and 11 -> d_out=0 both. net_ro=1 after reset is released; net_so=0.
2. Write 10 with 64'hC010_0000_1111_1111, net_ri=1, net_polarity=1 -> next cycle net_so=1, net_do=that value. One cycle later out_full=0; read 11 returns 0.
3. Same packet with net_polarity=0 for 3 cycles, then 1 -> net_so stays 0 for 3 cycles, then pulses 1 for exactly one cycle.
4. With out_full=1 and net_ri=0, write 10 with 64'h4000_0000_2222_2222 -> dropped. After net_ri=1, the original 64'hC010_0000_1111_1111 is sent.
5. Router drives net_si=1, net_di=64'h8001_0000_3333_3333 -> net_ro drops next cycle; read 01 = 1. Read 00 -> d_out=64'h8001_0000_3333_3333 the cycle after. net_ro returns to 1 and a second held net_si packet is accepted the next cycle.
6. With both buffers full, assert reset for 1 cycle -> in_full=out_full=0, d_out=0, net_so=0. net_ro=1 the cycle after reset deasserts.
